// File: rtl/simon_pkg.sv
// Shared constants and encodings for the Simon datapath and its controller.
package simon_pkg;

  localparam int unsigned SIMON_WIDTH  = 4;
  localparam int unsigned SIMON_DEPTH  = 64;
  localparam int unsigned SIMON_ADDR_W = 6;

  typedef enum logic {
    LEVEL_EASY = 1'b0,
    LEVEL_HARD = 1'b1
  } level_e;

  typedef enum logic {
    LED_PATTERN = 1'b0,
    LED_MEM     = 1'b1
  } led_mode_e;

endpackage

// File: rtl/simon_datapath_if.sv
// Control strobes from the Simon controller and status flags returned to it.
interface simon_datapath_if;

  logic load_level;
  logic count_cnt;
  logic count_clr;
  logic index_cnt;
  logic index_clr;
  logic w_en;
  logic disp_mem;

  logic pattern_valid;
  logic index_lt_count;
  logic pattern_eq_mem;

  modport master (
    output load_level, count_cnt, count_clr, index_cnt, index_clr, w_en, disp_mem,
    input  pattern_valid, index_lt_count, pattern_eq_mem
  );

  modport slave (
    input  load_level, count_cnt, count_clr, index_cnt, index_clr, w_en, disp_mem,
    output pattern_valid, index_lt_count, pattern_eq_mem
  );

endinterface

// File: rtl/simon_pattern_mem.sv
// DEPTH x WIDTH pattern store: async clear, guarded synchronous write,
// combinational read that returns zero for the one-past-end address.
module simon_pattern_mem
  import simon_pkg::*;
#(
  parameter int unsigned WIDTH  = SIMON_WIDTH,
  parameter int unsigned DEPTH  = SIMON_DEPTH,
  parameter int unsigned ADDR_W = SIMON_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W:0]   waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W:0]   raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Addresses never exceed DEPTH, so the top bit alone marks out-of-range.
  always_comb begin
    mem_d = mem_q;
    if (we && !waddr[ADDR_W]) begin
      mem_d[waddr[ADDR_W-1:0]] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = raddr[ADDR_W] ? '0 : mem_q[raddr[ADDR_W-1:0]];

endmodule

// File: rtl/simon_datapath.sv
// Simon datapath: level register, count/index counters, pattern store and LED mux.
// Optional high-score register enabled by SIMON_HIGH_SCORE_EN.
module simon_datapath
  import simon_pkg::*;
#(
  parameter int unsigned WIDTH  = SIMON_WIDTH,
  parameter int unsigned DEPTH  = SIMON_DEPTH,
  parameter int unsigned ADDR_W = SIMON_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              level_sw,
  input  logic [WIDTH-1:0]  pattern,
  simon_datapath_if.slave   ctl,
  output logic [WIDTH-1:0]  pattern_leds,
  output logic              level
`ifdef SIMON_HIGH_SCORE_EN
  ,
  output logic [ADDR_W:0]   high_score
`endif
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

  level_e           level_q, level_d;
  logic [ADDR_W:0]  count_q, count_d;
  logic [ADDR_W:0]  index_q, index_d;
  logic [WIDTH-1:0] rd_data;

  always_comb begin
    level_d = level_q;
    if (ctl.load_level) begin
      level_d = level_e'(level_sw);
    end

    count_d = count_q;
    if (ctl.count_clr) begin
      count_d = '0;
    end else if (ctl.count_cnt && count_q != FULL) begin
      count_d = count_q + 1'b1;
    end

    index_d = index_q;
    if (ctl.index_clr) begin
      index_d = '0;
    end else if (ctl.index_cnt && index_q < count_q) begin
      index_d = index_q + 1'b1;
    end
    // A lone count_clr would otherwise leave index above count.
    if (index_d > count_d) begin
      index_d = count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= LEVEL_EASY;
      count_q <= '0;
      index_q <= '0;
    end else begin
      level_q <= level_d;
      count_q <= count_d;
      index_q <= index_d;
    end
  end

  simon_pattern_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (ctl.w_en),
    .waddr (count_q),
    .wdata (pattern),
    .raddr (index_q),
    .rdata (rd_data)
  );

  assign level              = level_q;
  assign ctl.pattern_valid  = (level_q == LEVEL_HARD) ||
                              ((pattern != '0) && ((pattern & (pattern - 1'b1)) == '0));
  assign ctl.index_lt_count = index_q < count_q;
  assign ctl.pattern_eq_mem = !index_q[ADDR_W] && (pattern == rd_data);
  assign pattern_leds       = (led_mode_e'(ctl.disp_mem) == LED_MEM) ? rd_data : pattern;

`ifdef SIMON_HIGH_SCORE_EN
  logic [ADDR_W:0] high_score_q, high_score_d;

  always_comb begin
    high_score_d = high_score_q;
    if (ctl.count_clr && count_q > high_score_q) begin
      high_score_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      high_score_q <= '0;
    end else begin
      high_score_q <= high_score_d;
    end
  end

  assign high_score = high_score_q;
`endif

endmodule

// File: tb/tb_simon_datapath.sv
// Directed bench for simon_datapath; expectations queued by stimulus, checked by a negedge monitor.
module tb_simon_datapath;
  import simon_pkg::*;

  localparam int unsigned S_VALID = 0;
  localparam int unsigned S_LT    = 1;
  localparam int unsigned S_EQ    = 2;
  localparam int unsigned S_LEDS  = 3;
  localparam int unsigned S_LEVEL = 4;
  localparam int unsigned S_HS    = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       level_sw;
  logic [3:0] pattern;
  logic [3:0] pattern_leds;
  logic       level;
`ifdef SIMON_HIGH_SCORE_EN
  logic [6:0] high_score;
`endif

  simon_datapath_if ctl_if();

  simon_datapath #(
    .WIDTH  (4),
    .DEPTH  (64),
    .ADDR_W (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .level_sw     (level_sw),
    .pattern      (pattern),
    .ctl          (ctl_if),
    .pattern_leds (pattern_leds),
    .level        (level)
`ifdef SIMON_HIGH_SCORE_EN
    ,
    .high_score   (high_score)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned sig;
    logic [7:0]  exp;
  } chk_t;

  chk_t        sb[$];
  chk_t        cur;
  int unsigned total  = 0;
  int unsigned passed = 0;

  function automatic logic [7:0] actual(int unsigned sig);
    case (sig)
      S_VALID: return {7'd0, ctl_if.pattern_valid};
      S_LT:    return {7'd0, ctl_if.index_lt_count};
      S_EQ:    return {7'd0, ctl_if.pattern_eq_mem};
      S_LEDS:  return {4'd0, pattern_leds};
      S_LEVEL: return {7'd0, level};
`ifdef SIMON_HIGH_SCORE_EN
      S_HS:    return {1'b0, high_score};
`endif
      default: return 8'hxx;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      total++;
      if (actual(cur.sig) === cur.exp) begin
        passed++;
      end else begin
        $display("FAIL %s: got %0h expected %0h at %0t", cur.name, actual(cur.sig), cur.exp, $time);
      end
    end
  end

  task automatic expect_sig(input string name, input int unsigned sig, input logic [7:0] exp);
    chk_t c;
    c.name = name;
    c.sig  = sig;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  task automatic expect_hs(input string name, input logic [7:0] exp);
`ifdef SIMON_HIGH_SCORE_EN
    expect_sig(name, S_HS, exp);
`else
    if (exp === 8'hxx) $display("unused %s", name);
`endif
  endtask

  task automatic clr_strobes();
    ctl_if.load_level = 1'b0;
    ctl_if.count_cnt  = 1'b0;
    ctl_if.count_clr  = 1'b0;
    ctl_if.index_cnt  = 1'b0;
    ctl_if.index_clr  = 1'b0;
    ctl_if.w_en       = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr_strobes();
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    level_sw = 1'b0;
    pattern = 4'b0000;
    ctl_if.disp_mem = 1'b0;
    clr_strobes();

    // Reset state
    expect_sig("rst_lt", S_LT, 8'd0);
    expect_sig("rst_level", S_LEVEL, 8'd0);
    expect_sig("rst_eq", S_EQ, 8'd1);
    expect_sig("rst_leds", S_LEDS, 8'd0);
    expect_sig("rst_valid", S_VALID, 8'd0);
    expect_hs("rst_hs", 8'd0);
    settle();
    rst = 1'b1;

    // Level register and hard-level validity
    level_sw = 1'b1; ctl_if.load_level = 1'b1; step();
    pattern = 4'b0110;
    expect_sig("level_hard", S_LEVEL, 8'd1);
    expect_sig("hard_valid_0110", S_VALID, 8'd1);
    expect_sig("leds_follow_pattern", S_LEDS, 8'h6);
    settle();

    // Easy validity
    level_sw = 1'b0; ctl_if.load_level = 1'b1; step();
    pattern = 4'b0100;
    expect_sig("level_easy", S_LEVEL, 8'd0);
    expect_sig("easy_valid_0100", S_VALID, 8'd1);
    settle();
    pattern = 4'b0110;
    expect_sig("easy_valid_0110", S_VALID, 8'd0);
    settle();
    pattern = 4'b0000;
    expect_sig("easy_valid_0000", S_VALID, 8'd0);
    settle();

    // Write/playback and compare
    pattern = 4'b0010; ctl_if.w_en = 1'b1; ctl_if.count_cnt = 1'b1; step();
    ctl_if.disp_mem = 1'b1;
    expect_sig("play_leds", S_LEDS, 8'h2);
    expect_sig("play_lt", S_LT, 8'd1);
    expect_sig("eq_match", S_EQ, 8'd1);
    settle();
    pattern = 4'b0001;
    expect_sig("eq_mismatch", S_EQ, 8'd0);
    expect_sig("leds_mem_not_pattern", S_LEDS, 8'h2);
    settle();
    ctl_if.index_cnt = 1'b1; step();
    expect_sig("idx1_lt", S_LT, 8'd0);
    expect_sig("idx1_leds", S_LEDS, 8'h0);
    settle();

    // Clear priority over increment
    ctl_if.index_clr = 1'b1; ctl_if.count_cnt = 1'b1; ctl_if.count_clr = 1'b1; step();
    expect_sig("count_clr_prio", S_LT, 8'd0);
    expect_hs("hs_after_clr1", 8'd1);
    settle();
    ctl_if.count_cnt = 1'b1; step();
    ctl_if.index_cnt = 1'b1; ctl_if.index_clr = 1'b1; step();
    expect_sig("index_clr_prio", S_LT, 8'd1);
    settle();

    // Fill to DEPTH, then saturate
    ctl_if.count_clr = 1'b1; ctl_if.index_clr = 1'b1; step();
    for (int i = 0; i < 64; i++) begin
      pattern = 4'(1 << (i % 4));
      ctl_if.w_en = 1'b1; ctl_if.count_cnt = 1'b1; step();
    end
    for (int i = 0; i < 3; i++) begin
      pattern = 4'hF;
      ctl_if.w_en = 1'b1; ctl_if.count_cnt = 1'b1; step();
    end
    pattern = 4'h0;
    ctl_if.index_clr = 1'b1; step();
    expect_sig("full_write_ignored_mem0", S_LEDS, 8'h1);
    expect_sig("full_idx0_lt", S_LT, 8'd1);
    settle();
    for (int i = 0; i < 63; i++) begin
      ctl_if.index_cnt = 1'b1; step();
    end
    expect_sig("idx63_lt", S_LT, 8'd1);
    expect_sig("idx63_leds", S_LEDS, 8'h8);
    settle();
    ctl_if.index_cnt = 1'b1; step();
    expect_sig("idx64_lt", S_LT, 8'd0);
    expect_sig("idx64_leds_zero", S_LEDS, 8'h0);
    expect_sig("idx64_eq_zero", S_EQ, 8'd0);
    settle();
    ctl_if.index_cnt = 1'b1; step();
    expect_sig("idx_sat_leds", S_LEDS, 8'h0);
    expect_sig("idx_sat_lt", S_LT, 8'd0);
    settle();
    ctl_if.count_clr = 1'b1; ctl_if.index_clr = 1'b1; step();
    expect_hs("hs_64", 8'd64);
    expect_sig("clr_after_full_lt", S_LT, 8'd0);
    settle();

    // Async reset mid-sequence
    level_sw = 1'b1; ctl_if.load_level = 1'b1; step();
    pattern = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      ctl_if.w_en = 1'b1; ctl_if.count_cnt = 1'b1; step();
    end
    for (int i = 0; i < 3; i++) begin
      ctl_if.index_cnt = 1'b1; step();
    end
    expect_sig("pre_rst_lt", S_LT, 8'd1);
    expect_sig("pre_rst_leds", S_LEDS, 8'h8);
    expect_sig("pre_rst_eq", S_EQ, 8'd1);
    expect_sig("pre_rst_level", S_LEVEL, 8'd1);
    settle();
    @(posedge clk);
    #2;
    rst = 1'b0;
    expect_sig("async_rst_lt", S_LT, 8'd0);
    expect_sig("async_rst_level", S_LEVEL, 8'd0);
    expect_sig("async_rst_leds", S_LEDS, 8'h0);
    expect_sig("async_rst_eq", S_EQ, 8'd0);
    expect_sig("async_rst_valid", S_VALID, 8'd1);
    expect_hs("async_rst_hs", 8'd0);
    settle();
    rst = 1'b1;
    ctl_if.index_cnt = 1'b1; step();
    expect_sig("post_rst_idx_lt", S_LT, 8'd0);
    expect_sig("post_rst_leds", S_LEDS, 8'h0);
    settle();

    settle();
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      total += sb.size();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/simon_datapath.md
Name: simon_datapath

Overview:
- Datapath stage paired with the Simon control FSM: consumes its control strobes (count_cnt/clr, index_cnt/clr, w_en, disp_mem, load_level) and returns the status flags (pattern_valid, index_lt_count, pattern_eq_mem).
- Holds the level register, the stored pattern sequence, the count and index counters, and the LED output mux.
- Sits between the switch inputs and the pattern LEDs, directly alongside the controller.

Parameters:
- WIDTH, 4, bits per pattern (switches/LEDs).
- DEPTH, 64, maximum stored patterns; must be a power of two.
- ADDR_W, 6, log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- level_sw  in  1  level select switch: 0 = easy, 1 = hard.
- pattern  in  WIDTH  switch pattern.
- load_level  in  1  capture level_sw into the level register.
- count_cnt  in  1  increment count.
- count_clr  in  1  clear count.
- index_cnt  in  1  increment index.
- index_clr  in  1  clear index.
- w_en  in  1  write pattern to mem[count].
- disp_mem  in  1  LED source select: 1 = mem[index], 0 = pattern.
- pattern_valid  out  1  current pattern is legal for the level.
- index_lt_count  out  1  index < count.
- pattern_eq_mem  out  1  pattern == mem[index].
- pattern_leds  out  WIDTH  LED drive.
- level  out  1  registered level.

Behaviour:
- Reset (rst=0, asynchronous):
  - level=0, count=0, index=0.
  - All DEPTH memory entries = 0.
  - Resulting outputs: index_lt_count=0, pattern_eq_mem=(pattern==0), pattern_leds follow disp_mem.
- Level register: loads level_sw on a clock edge with load_level=1; holds otherwise.
- pattern_valid (combinational):
  - level=0: 1 only when pattern has exactly one bit set (one-hot); pattern=0 is invalid.
  - level=1: always 1.
- count, index: ADDR_W+1 bits wide, so the value DEPTH is representable.
- Count register, per edge:
  - clr has priority over cnt.
  - cnt increments and saturates at DEPTH.
- Index register, per edge:
  - clr has priority over cnt.
  - cnt increments and saturates at count; index never exceeds count.
- Memory write:
  - Synchronous: mem[count[ADDR_W-1:0]] <= pattern when w_en=1 and count<DEPTH.
  - w_en at count==DEPTH is ignored; no wrap, no corruption of mem[0].
  - Write and count_cnt on the same edge: the write uses the old count; count then advances.
- Memory read: combinational at index[ADDR_W-1:0].
  - When index==DEPTH, the read value is forced to 0 and pattern_eq_mem=0.
- index_lt_count: unsigned compare index<count, combinational, zero latency.
- pattern_eq_mem: combinational; a same-edge write becomes visible after the edge.
- pattern_leds = disp_mem ? mem[index] : pattern, combinational.
- Reset mid-operation: all state returns to reset values immediately and asynchronously; stored sequence is lost.
- No internal FSM; sequencing is owned by the controller. This block is counters + register file + compare.

Optional Feature:
- Macro: SIMON_HIGH_SCORE_EN.
- Defined:
  - Adds port high_score (output, ADDR_W+1 bits).
  - Register reset to 0 by rst; updated to count whenever count_clr is asserted and count > high_score, sampled before the clear.
  - Otherwise holds.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Shared package (simon_pkg): WIDTH/DEPTH/ADDR_W defaults, LEVEL_EASY=1'b0, LEVEL_HARD=1'b1.
  - LED mode encodings also move there for reuse by the controller.
- One natural sub-module: simon_pattern_mem.
  - DEPTH x WIDTH register file, asynchronous-reset to 0, synchronous write with full guard, combinational read with out-of-range zero.
- Counters and compare logic stay in the top module.

Test Plan:
- Reset/level: rst=0 → count=0, index=0, level=0. Release, level_sw=1, load_level pulse → level=1. Then pattern=4'b0110 → pattern_valid=1.
- Easy validity: level=0; pattern=4'b0100 → pattern_valid=1; 4'b0110 → 0; 4'b0000 → 0.
- Write/playback: pattern=4'b0010, w_en+count_cnt one edge → mem[0]=4'b0010, count=1.
  - With disp_mem=1, index=0 → pattern_leds=4'b0010, index_lt_count=1.
  - index_cnt → index=1, index_lt_count=0.
- Compare: index=0, mem[0]=4'b0010; pattern=4'b0010 → pattern_eq_mem=1; pattern=4'b0001 → 0.
- Priority/saturation:
  - count_cnt+count_clr same edge → count=0.
  - Fill to DEPTH=64, further count_cnt → count stays 64.
  - w_en at full → mem[0] unchanged.
  - index_cnt at index==count → index unchanged.
- Async reset mid-sequence: count=5, index=3, drop rst between edges → count=0, index=0, memory zero, before the next clk edge. With SIMON_HIGH_SCORE_EN, high_score=0.
